dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 137 +++++++++++++
 tb/tb_dmem_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-masked single-cycle writes, reads with a configurable
// number of wait states, and out-of-range detection on the upper address bits.
//
// state | meaning
// IDLE  | ready; writes complete here, reads are latched here
// WAIT  | read wait states, counter running down to 0
// RESP  | read word presented, op_data_valid high
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    input  logic        ip_data_rd,
    output logic        op_data_valid,
    output logic [31:0] op_data_from_dmem,
    output logic        op_busy,
    output logic        op_addr_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_nxt;
    logic [AW-1:0] r_idx;
    logic          r_oor;
    logic [31:0]   r_rdata;
    logic          r_addr_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic          w_acc_wr;
    logic          w_acc_rd;
    logic          w_capture;
    logic          w_cap_from_in;
    logic          w_err_nxt;
    logic [AW-1:0] w_rd_idx;
    logic          w_rd_oor;
    logic [31:0]   w_rdata;

    assign w_idx = ip_data_addr[AW+1:2];
    assign w_oor = (ip_data_addr >> (AW + 2)) != 32'd0;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_acc_wr      = 1'b0;
        w_acc_rd      = 1'b0;
        w_capture     = 1'b0;
        w_cap_from_in = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // a simultaneous read is dropped: write wins
                if (ip_data_wr) begin
                    w_acc_wr  = 1'b1;
                    w_err_nxt = w_oor;
                end else if (ip_data_rd) begin
                    w_acc_rd = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt   = S_RESP;
                        w_capture     = 1'b1;
                        w_cap_from_in = 1'b1;
                        w_err_nxt     = w_oor;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = S_RESP;
                    w_capture   = 1'b1;
                    w_err_nxt   = r_oor;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // zero-wait reads capture straight from the request; others from the latched copy
    assign w_rd_idx = w_cap_from_in ? w_idx : r_idx;
    assign w_rd_oor = w_cap_from_in ? w_oor : r_oor;
    assign w_rdata  = w_rd_oor ? 32'h0000_0000 : r_mem[w_rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_idx      <= '0;
            r_oor      <= 1'b0;
            r_rdata    <= 32'h0000_0000;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr_err <= w_err_nxt;
            if (w_acc_rd) begin
                r_idx <= w_idx;
                r_oor <= w_oor;
            end
            if (w_capture) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // RAM is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk) begin
        if (reset && w_acc_wr && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (ip_data_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= ip_data_from_proc[8*i +: 8];
                end
            end
        end
    end

    assign op_busy           = (r_state != S_IDLE);
    assign op_data_valid     = (r_state == S_RESP);
    assign op_data_from_dmem = r_rdata;
    assign op_addr_err       = r_addr_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (1, 0 and 3 wait states) checked against a
// word-array memory model with latency derived from the wait-state count.
module tb_dmem_ctrl;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  mask  [3];
    logic        wr    [3];
    logic        rd    [3];
    logic        valid [3];
    logic        busy  [3];
    logic        aerr  [3];
    logic [31:0] dout  [3];

    logic [31:0] mm [3][16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut_ws1 (
        .clk(clk), .reset(reset), .ip_data_addr(addr[0]), .ip_data_wr(wr[0]),
        .ip_data_mask(mask[0]), .ip_data_from_proc(wdata[0]), .ip_data_rd(rd[0]),
        .op_data_valid(valid[0]), .op_data_from_dmem(dout[0]), .op_busy(busy[0]),
        .op_addr_err(aerr[0]));

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(reset), .ip_data_addr(addr[1]), .ip_data_wr(wr[1]),
        .ip_data_mask(mask[1]), .ip_data_from_proc(wdata[1]), .ip_data_rd(rd[1]),
        .op_data_valid(valid[1]), .op_data_from_dmem(dout[1]), .op_busy(busy[1]),
        .op_addr_err(aerr[1]));

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut_ws3 (
        .clk(clk), .reset(reset), .ip_data_addr(addr[2]), .ip_data_wr(wr[2]),
        .ip_data_mask(mask[2]), .ip_data_from_proc(wdata[2]), .ip_data_rd(rd[2]),
        .op_data_valid(valid[2]), .op_data_from_dmem(dout[2]), .op_busy(busy[2]),
        .op_addr_err(aerr[2]));

    function automatic int ws_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic oor(input logic [31:0] a);
        return a >= 32'(DEPTH * 4);
    endfunction

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy[d] === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout d%0d: busy %b want 0", d, busy[d]);
        end
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [3:0] m,
                            input logic [31:0] dt, input logic with_rd);
        logic seen_valid = 1'b0;
        logic seen_busy  = 1'b0;
        wait_idle(d);
        addr[d] = a; mask[d] = m; wdata[d] = dt; wr[d] = 1'b1; rd[d] = with_rd;
        @(posedge clk);
        @(negedge clk);
        wr[d] = 1'b0;
        rd[d] = 1'b0;
        if (!oor(a)) begin
            for (int i = 0; i < 4; i++)
                if (m[i]) mm[d][a[5:2]][8*i +: 8] = dt[8*i +: 8];
        end
        checks++;
        if (busy[d] !== 1'b0) begin errors++; $display("FAIL wr_busy d%0d: got %b want 0", d, busy[d]); end
        checks++;
        if (aerr[d] !== oor(a)) begin errors++; $display("FAIL wr_addr_err d%0d a=%h: got %b want %b", d, a, aerr[d], oor(a)); end
        checks++;
        if (valid[d] !== 1'b0) begin errors++; $display("FAIL wr_valid d%0d: got %b want 0", d, valid[d]); end
        if (with_rd) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (valid[d] !== 1'b0) seen_valid = 1'b1;
                if (busy[d] !== 1'b0) seen_busy = 1'b1;
            end
            checks++;
            if (seen_valid || seen_busy) begin
                errors++;
                $display("FAIL wr_rd_dropped d%0d: valid_seen %b busy_seen %b want 0 0", d, seen_valid, seen_busy);
            end
        end
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input string nm);
        logic [31:0] exp_data;
        logic        exp_err;
        int          lat = 0;
        int          nbusy = 0;
        logic        pre_err = 1'b0;
        wait_idle(d);
        exp_err  = oor(a);
        exp_data = exp_err ? 32'h0 : mm[d][a[5:2]];
        addr[d] = a; rd[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd[d] = 1'b0;
        addr[d] = $urandom;
        while (valid[d] !== 1'b1 && lat < 20) begin
            if (busy[d] === 1'b1) nbusy++;
            if (aerr[d] !== 1'b0) pre_err = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (busy[d] === 1'b1) nbusy++;
        checks++;
        if (lat !== ws_of(d)) begin errors++; $display("FAIL %s latency d%0d: got %0d want %0d", nm, d, lat, ws_of(d)); end
        checks++;
        if (nbusy !== ws_of(d) + 1) begin errors++; $display("FAIL %s busy_cycles d%0d: got %0d want %0d", nm, d, nbusy, ws_of(d) + 1); end
        checks++;
        if (dout[d] !== exp_data) begin errors++; $display("FAIL %s data d%0d a=%h: got %h want %h", nm, d, a, dout[d], exp_data); end
        checks++;
        if (aerr[d] !== exp_err || pre_err) begin
            errors++;
            $display("FAIL %s addr_err d%0d: got %b early %b want %b early 0", nm, d, aerr[d], pre_err, exp_err);
        end
        @(negedge clk);
        checks++;
        if (valid[d] !== 1'b0 || busy[d] !== 1'b0 || aerr[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s after_resp d%0d: valid %b busy %b err %b want 0 0 0", nm, d, valid[d], busy[d], aerr[d]);
        end
        checks++;
        if (dout[d] !== exp_data) begin errors++; $display("FAIL %s data_hold d%0d: got %h want %h", nm, d, dout[d], exp_data); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            addr[d] = '0; wdata[d] = '0; mask[d] = '0; wr[d] = 1'b0; rd[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (valid[d] !== 1'b0) begin errors++; $display("FAIL rst_valid d%0d: got %b want 0", d, valid[d]); end
            checks++;
            if (busy[d] !== 1'b0) begin errors++; $display("FAIL rst_busy d%0d: got %b want 0", d, busy[d]); end
            checks++;
            if (aerr[d] !== 1'b0) begin errors++; $display("FAIL rst_err d%0d: got %b want 0", d, aerr[d]); end
            checks++;
            if (dout[d] !== 32'h0) begin errors++; $display("FAIL rst_data d%0d: got %h want 0", d, dout[d]); end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_init();
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 16; w++)
                do_write(d, 32'(w * 4), 4'hF, $urandom, 1'b0);
    endtask

    task automatic test_directed();
        do_write(0, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
        do_read(0, 32'h10, "raw_full");
        do_write(0, 32'h12, 4'b0100, 32'h00AB_0000, 1'b0);
        do_read(0, 32'h10, "byte_lane");
        checks++;
        if (dout[0] !== 32'hDEAB_BEEF) begin errors++; $display("FAIL byte_lane_const: got %h want deabbeef", dout[0]); end
        do_write(0, 32'h14, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        do_read(0, 32'h14, "mask_zero");
        do_write(0, 32'h0000_1000, 4'hF, 32'h5555_AAAA, 1'b0);
        do_read(0, 32'h0000_1000, "oor_read");
        do_read(0, 32'h0, "oor_alias_intact");
    endtask

    task automatic test_busy_ignore();
        int n = 0;
        wait_idle(0);
        addr[0] = 32'h10; rd[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd[0] = 1'b0;
        addr[0] = 32'h20; wdata[0] = 32'h1111_2222; mask[0] = 4'hF; wr[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr[0] = 1'b0;
        checks++;
        if (valid[0] !== 1'b1 || dout[0] !== mm[0][4]) begin
            errors++;
            $display("FAIL busy_read_resp: valid %b data %h want 1 %h", valid[0], dout[0], mm[0][4]);
        end
        do_read(0, 32'h20, "busy_dropped");

        addr[0] = 32'h10; rd[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd[0] = 1'b0;
        addr[0] = 32'h20; wdata[0] = 32'h3333_4444; mask[0] = 4'hF; wr[0] = 1'b1;
        while (busy[0] === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        wr[0] = 1'b0;
        mm[0][8] = 32'h3333_4444;
        do_read(0, 32'h20, "busy_held");
    endtask

    task automatic test_reset_abort();
        logic seen = 1'b0;
        wait_idle(0);
        wait_idle(2);
        addr[0] = 32'h10; rd[0] = 1'b1;
        addr[2] = 32'h10; rd[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd[0] = 1'b0;
        rd[2] = 1'b0;
        reset = 1'b0;
        addr[1] = 32'h8; wdata[1] = 32'h1234_5678; mask[1] = 4'hF; wr[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (valid[d] !== 1'b0 || busy[d] !== 1'b0 || aerr[d] !== 1'b0 || dout[d] !== 32'h0) begin
                errors++;
                $display("FAIL abort_in_reset d%0d: valid %b busy %b err %b data %h want 0 0 0 0",
                         d, valid[d], busy[d], aerr[d], dout[d]);
            end
        end
        wr[1] = 1'b0;
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++)
                if (valid[d] !== 1'b0 || busy[d] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_no_valid: activity seen %b want 0", seen); end
        do_read(0, 32'h10, "abort_reread");
        do_read(2, 32'h10, "abort_reread_ws3");
        do_read(1, 32'h8, "no_accept_in_reset");
    endtask

    task automatic test_back_to_back();
        wait_idle(1);
        addr[1] = 32'h0; rd[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid[1] !== 1'b1 || dout[1] !== mm[1][0]) begin
            errors++;
            $display("FAIL b2b_first: valid %b data %h want 1 %h", valid[1], dout[1], mm[1][0]);
        end
        addr[1] = 32'h4;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: valid %b busy %b want 0 0", valid[1], busy[1]);
        end
        @(posedge clk);
        @(negedge clk);
        rd[1] = 1'b0;
        checks++;
        if (valid[1] !== 1'b1 || dout[1] !== mm[1][1]) begin
            errors++;
            $display("FAIL b2b_second: valid %b data %h want 1 %h", valid[1], dout[1], mm[1][1]);
        end
        @(negedge clk);
        do_write(1, 32'h4, 4'hF, 32'hC0FF_EE00, 1'b1);
        do_read(1, 32'h4, "rdwr_write_only");
    endtask

    task automatic test_random(input int d, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = (32'h1 << $urandom_range(12, 31)) | 32'($urandom_range(0, 4095));
            else
                a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0)
                do_write(d, a, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 3) == 0));
            else
                do_read(d, a, "rand_read");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random(0, 80);
        test_random(1, 80);
        test_random(2, 80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
